// File: rtl/swizzle_cram_to_dram_pkg.sv
// swizzle_cram_to_dram_pkg: geometry and FSM encoding shared by the CRAM<->DRAM swizzle paths
package swizzle_cram_to_dram_pkg;
  localparam int DWIDTH = 40;
  localparam int AWIDTH = 9;
  localparam int RAM_NUM_WORDS = 512;
  localparam logic [AWIDTH-1:0] RAM_START_ADDR = '0;
  localparam logic [31:0] RAM_START_NUM = '0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} swz_state_e;
endpackage

// File: rtl/swizzle_out_fifo.sv
// swizzle_out_fifo: register-based synchronous FIFO with occupancy count
module swizzle_out_fifo #(
  parameter int DW = 40,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           din,
  output logic [DW-1:0]           dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/swizzle_cram_to_dram.sv
// swizzle_cram_to_dram: streams CRAM words to the memory controller through a credit-limited FIFO
module swizzle_cram_to_dram
  import swizzle_cram_to_dram_pkg::*;
#(
  parameter int RAM_RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       xfer_words,
  input  logic [31:0]       start_ram_num,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_re,
  output logic [31:0]       ram_num,
  input  logic [DWIDTH-1:0] ram_data_in,
  output logic [DWIDTH-1:0] mem_ctrl_data_out,
  output logic              mem_ctrl_valid,
  input  logic              mem_ctrl_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  swz_state_e state;
  logic [31:0] xfer, issued, sent;
  logic [CW-1:0] inflight, fifo_count;
  logic [RAM_RD_LATENCY-1:0] vld_sr;
  logic push, pop, empty, full, credit_ok, last_addr;
  assign push = vld_sr[RAM_RD_LATENCY-1];
  assign pop = mem_ctrl_valid && mem_ctrl_ready;
  assign mem_ctrl_valid = !empty;
  // ram_re is the read being presented now; it already owns a slot, and pops are not credited
  assign credit_ok = 32'(fifo_count) + 32'(inflight) + 32'(ram_re) < 32'(FIFO_DEPTH);
  assign last_addr = ram_addr == AWIDTH'(RAM_NUM_WORDS - 1);
  swizzle_out_fifo #(.DW(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .reset,
    .push(push && !full),
    .pop,
    .din(ram_data_in),
    .dout(mem_ctrl_data_out),
    .count(fifo_count),
    .empty,
    .full
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      ram_re <= 1'b0;
      ram_addr <= RAM_START_ADDR;
      ram_num <= RAM_START_NUM;
      xfer <= '0;
      issued <= '0;
      sent <= '0;
      inflight <= '0;
      vld_sr <= '0;
    end else begin
      ram_re <= 1'b0;
      done <= 1'b0;
      inflight <= inflight + CW'(ram_re) - CW'(push);
      vld_sr[0] <= ram_re;
      for (int i = 1; i < RAM_RD_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
      if (pop) sent <= sent + 1;
      case (state)
        IDLE: if (start) begin
          if (xfer_words == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            xfer <= xfer_words;
            busy <= 1'b1;
            ram_re <= 1'b1;
            ram_addr <= RAM_START_ADDR;
            ram_num <= start_ram_num;
            issued <= 32'd1;
            sent <= '0;
            state <= xfer_words == 32'd1 ? DRAIN : RUN;
          end
        end
        RUN: if (credit_ok) begin
          ram_re <= 1'b1;
          issued <= issued + 1;
          ram_addr <= last_addr ? RAM_START_ADDR : ram_addr + 1'b1;
          ram_num <= last_addr ? ram_num + 1 : ram_num;
          if (issued == xfer - 1) state <= DRAIN;
        end
        DRAIN: if (pop && sent == xfer - 1) begin
          state <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule
